// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve / predict unit.
package branch_pkg;

    // Conditional-branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 2-bit saturating direction counter
    typedef logic [1:0] ctr_t;
    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    // Table indexing modes
    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    // Next counter value: move toward the resolved direction, hold at the ends
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != CTR_ST) nxt = cur + 2'd1;
        end else begin
            if (cur != CTR_SNT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_resolve_cond_eval.sv
// Branch condition evaluation from ALU flags; funct3 010/011 are not branches.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zflag,
    input  logic       cflag,
    input  logic       oflag,
    input  logic       nflag,
    output logic       taken,
    output logic       valid
);

    // Decode funct3 into a direction; C is the carry of rs1+~rs2+1, so !C means rs1 < rs2 unsigned
    always_comb begin
        taken = 1'b0;
        valid = 1'b1;
        case (funct3)
            F3_BEQ:  taken = zflag;
            F3_BNE:  taken = ~zflag;
            F3_BLT:  taken = nflag ^ oflag;
            F3_BGE:  taken = ~(nflag ^ oflag);
            F3_BLTU: taken = ~cflag;
            F3_BGEU: taken = cflag;
            default: begin
                taken = 1'b0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// Execute-stage branch resolution plus a BHT-based fetch predictor
// (bimodal or gshare) with saturating branch / mispredict statistics.
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int MODE     = 0,
    parameter int GHR_W    = 6,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             predict_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [2:0]       ex_funct3,
    input  logic             ex_pred_taken,
    input  logic             Zflag,
    input  logic             Cflag,
    input  logic             Oflag,
    input  logic             Nflag,
    output logic             branch_taken,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    ctr_t                bht [ENTRIES];
    logic [GHR_W-1:0]    ghr;
    logic [IDX_BITS-1:0] fetch_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic                cond_taken;
    logic                cond_valid;
    logic                do_update;

    branch_cond_eval u_cond (
        .funct3 (ex_funct3),
        .zflag  (Zflag),
        .cflag  (Cflag),
        .oflag  (Oflag),
        .nflag  (Nflag),
        .taken  (cond_taken),
        .valid  (cond_valid)
    );

    assign do_update     = ex_valid & ex_branch & cond_valid;
    assign branch_taken  = do_update & cond_taken;
    assign mispredict    = do_update & (cond_taken != ex_pred_taken);

    // Both lookups hash with the current GHR, so a same-cycle fetch sees the pre-update table
    generate
        if (MODE == MODE_GSHARE) begin : g_gshare
            logic [IDX_BITS-1:0] hist;
            assign hist      = IDX_BITS'(ghr);
            assign fetch_idx = fetch_pc[IDX_BITS+1:2] ^ hist;
            assign ex_idx    = ex_pc[IDX_BITS+1:2] ^ hist;
        end else begin : g_bimodal
            assign fetch_idx = fetch_pc[IDX_BITS+1:2];
            assign ex_idx    = ex_pc[IDX_BITS+1:2];
        end
    endgenerate

    assign predict_taken = bht[fetch_idx][1];

    // PC bits outside the index field (and the GHR in bimodal mode) do not feed the table
    logic unused_bits;
    assign unused_bits = ^{fetch_pc[XLEN-1:IDX_BITS+2], fetch_pc[1:0],
                           ex_pc[XLEN-1:IDX_BITS+2], ex_pc[1:0], ghr};

    // Train the addressed counter toward the resolved direction
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= CTR_WNT;
        end else if (do_update) begin
            bht[ex_idx] <= ctr_next(bht[ex_idx], cond_taken);
        end
    end

    // Shift resolved directions into the global history (gshare only)
    generate
        if (MODE == MODE_GSHARE && GHR_W == 1) begin : g_ghr1
            always_ff @(posedge clk) begin
                if (rst)            ghr <= '0;
                else if (do_update) ghr <= cond_taken;
            end
        end else if (MODE == MODE_GSHARE) begin : g_ghrn
            always_ff @(posedge clk) begin
                if (rst)            ghr <= '0;
                else if (do_update) ghr <= {ghr[GHR_W-2:0], cond_taken};
            end
        end else begin : g_noghr
            assign ghr = '0;
        end
    endgenerate

    // Saturating statistics: count resolved branches and mispredictions
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (do_update) begin
            if (branch_count != '1)
                branch_count <= branch_count + CNT_W'(1);
            if (mispredict && mispredict_count != '1)
                mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench: resolution table, bimodal training, read-before-write,
// gshare history indexing and statistics saturation / reset.
module tb_branch_predict_resolve;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] fetch_pc, ex_pc;
    logic        ex_valid, ex_branch, ex_pred;
    logic [2:0]  f3;
    logic        z, c, o, n;
    int          sel;

    logic        pt_d, bt_d, mp_d;
    logic [15:0] bc_d, mc_d;
    logic        pt_g, bt_g, mp_g;
    logic [15:0] bc_g, mc_g;
    logic        pt_s, bt_s, mp_s;
    logic [3:0]  bc_s, mc_s;

    int total = 0;
    int passed = 0;

    branch_predict_resolve #(.MODE(0)) d (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .predict_taken(pt_d),
        .ex_valid(ex_valid && sel == 0), .ex_branch(ex_branch), .ex_pc(ex_pc),
        .ex_funct3(f3), .ex_pred_taken(ex_pred),
        .Zflag(z), .Cflag(c), .Oflag(o), .Nflag(n),
        .branch_taken(bt_d), .mispredict(mp_d),
        .branch_count(bc_d), .mispredict_count(mc_d)
    );

    branch_predict_resolve #(.MODE(1), .IDX_BITS(4), .GHR_W(4)) g (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .predict_taken(pt_g),
        .ex_valid(ex_valid && sel == 1), .ex_branch(ex_branch), .ex_pc(ex_pc),
        .ex_funct3(f3), .ex_pred_taken(ex_pred),
        .Zflag(z), .Cflag(c), .Oflag(o), .Nflag(n),
        .branch_taken(bt_g), .mispredict(mp_g),
        .branch_count(bc_g), .mispredict_count(mc_g)
    );

    branch_predict_resolve #(.MODE(0), .CNT_W(4)) s (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .predict_taken(pt_s),
        .ex_valid(ex_valid && sel == 2), .ex_branch(ex_branch), .ex_pc(ex_pc),
        .ex_funct3(f3), .ex_pred_taken(ex_pred),
        .Zflag(z), .Cflag(c), .Oflag(o), .Nflag(n),
        .branch_taken(bt_s), .mispredict(mp_s),
        .branch_count(bc_s), .mispredict_count(mc_s)
    );

    typedef struct {
        logic       v, b;
        logic [2:0] f3;
        logic       z, c, o, n, p;
        logic       exp_t, exp_m;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a conditional branch; only the Z flag matters for BEQ stimulus
    task automatic br(input logic [2:0] fn, input logic zf, input logic pred, input logic [31:0] pc);
        ex_valid  = 1'b1;
        ex_branch = 1'b1;
        f3 = fn; z = zf; c = 1'b0; o = 1'b0; n = 1'b0;
        ex_pred = pred;
        ex_pc = pc;
    endtask

    task automatic do_reset();
        ex_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        //          v  b  f3      z  c  o  n  p  t  m
        tbl[0]  = '{1, 1, 3'b000, 1, 0, 0, 0, 0, 1, 1}; // BEQ Z=1
        tbl[1]  = '{1, 1, 3'b001, 1, 0, 0, 0, 0, 0, 0}; // BNE Z=1
        tbl[2]  = '{1, 1, 3'b100, 0, 0, 0, 1, 0, 1, 1}; // BLT N=1 O=0
        tbl[3]  = '{1, 1, 3'b101, 0, 0, 1, 1, 0, 1, 1}; // BGE N=1 O=1
        tbl[4]  = '{1, 1, 3'b110, 0, 0, 0, 0, 0, 1, 1}; // BLTU C=0
        tbl[5]  = '{1, 1, 3'b111, 0, 0, 0, 0, 0, 0, 0}; // BGEU C=0
        tbl[6]  = '{1, 1, 3'b010, 1, 0, 0, 0, 1, 0, 0}; // invalid funct3
        tbl[7]  = '{1, 1, 3'b011, 1, 1, 1, 1, 1, 0, 0}; // invalid funct3
        tbl[8]  = '{1, 1, 3'b000, 0, 0, 0, 0, 1, 0, 1}; // BEQ Z=0, predicted T
        tbl[9]  = '{1, 1, 3'b111, 0, 1, 0, 0, 1, 1, 0}; // BGEU C=1, predicted T
        tbl[10] = '{1, 1, 3'b100, 0, 0, 1, 0, 0, 1, 1}; // BLT N=0 O=1
        tbl[11] = '{1, 1, 3'b101, 0, 0, 1, 0, 0, 0, 0}; // BGE N=0 O=1
        tbl[12] = '{0, 1, 3'b000, 1, 0, 0, 0, 0, 0, 0}; // not valid
        tbl[13] = '{1, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0}; // not a branch

        sel = 0; ex_valid = 0; ex_branch = 0; ex_pred = 0; f3 = 0;
        z = 0; c = 0; o = 0; n = 0; ex_pc = 0; fetch_pc = 32'h40;
        do_reset();

        // Reset state
        #1;
        chk("reset_predict", pt_d, 0);
        chk("reset_branch_count", bc_d, 0);
        chk("reset_mispredict_count", mc_d, 0);

        // Resolution table (ex_pc 0x200 maps to entry 0, away from later tests)
        for (int i = 0; i < 14; i++) begin
            ex_valid = tbl[i].v; ex_branch = tbl[i].b; f3 = tbl[i].f3;
            z = tbl[i].z; c = tbl[i].c; o = tbl[i].o; n = tbl[i].n;
            ex_pred = tbl[i].p; ex_pc = 32'h200;
            #1;
            chk($sformatf("vec%0d_taken", i), bt_d, tbl[i].exp_t);
            chk($sformatf("vec%0d_mispredict", i), mp_d, tbl[i].exp_m);
            tick();
        end
        ex_valid = 0;
        #1;
        chk("table_branch_count", bc_d, 10);
        chk("table_mispredict_count", mc_d, 6);

        // Bimodal training at 0x40
        do_reset();
        fetch_pc = 32'h40;
        br(3'b000, 1, 0, 32'h40);
        #1;
        chk("train_pred_initial", pt_d, 0);
        tick();
        chk("train_pred_after1", pt_d, 1);
        tick();
        tick();
        chk("train_pred_after3", pt_d, 1);
        chk("train_branch_count", bc_d, 3);
        chk("train_mispredict_count", mc_d, 3);
        br(3'b000, 0, 0, 32'h40);
        #1;
        chk("train_nt_no_mispredict", mp_d, 0);
        tick();
        chk("train_pred_after_nt1", pt_d, 1);
        tick();
        chk("train_pred_after_nt2", pt_d, 0);
        chk("train_branch_count5", bc_d, 5);
        chk("train_mispredict_count5", mc_d, 3);

        // Read-before-write at 0x80
        fetch_pc = 32'h80;
        br(3'b000, 1, 0, 32'h80);
        #1;
        chk("rbw_same_cycle", pt_d, 0);
        tick();
        ex_valid = 0;
        #1;
        chk("rbw_next_cycle", pt_d, 1);

        // Gshare: T,T,N,T at 0x10 trains entries 4,5,7,2 and leaves GHR=1101
        sel = 1;
        do_reset();
        br(3'b000, 1, 0, 32'h10); tick();
        br(3'b000, 1, 0, 32'h10); tick();
        br(3'b000, 0, 0, 32'h10); tick();
        br(3'b000, 1, 0, 32'h10); tick();
        ex_valid = 0;
        fetch_pc = 32'h3C; #1; chk("gs_entry2_ghr1101", pt_g, 1);
        fetch_pc = 32'h10; #1; chk("gs_entry9_before", pt_g, 0);
        fetch_pc = 32'h0C; #1; chk("gs_entry14", pt_g, 0);
        br(3'b000, 1, 0, 32'h10); tick();
        ex_valid = 0;
        // GHR now 1011
        fetch_pc = 32'h08; #1; chk("gs_entry9_after", pt_g, 1);
        fetch_pc = 32'h0C; #1; chk("gs_entry8_unchanged", pt_g, 0);
        fetch_pc = 32'h3C; #1; chk("gs_entry4", pt_g, 1);
        fetch_pc = 32'h30; #1; chk("gs_entry7", pt_g, 0);
        chk("gs_branch_count", bc_g, 5);
        chk("gs_mispredict_count", mc_g, 4);

        // Statistics saturation with 4-bit counters, then reset mid-stream
        sel = 2;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            br(3'b000, 1, 0, 32'h40);
            tick();
        end
        chk("sat_branch_count", bc_s, 15);
        chk("sat_mispredict_count", mc_s, 15);
        rst = 1;
        tick();
        chk("sat_rst_branch_count", bc_s, 0);
        chk("sat_rst_mispredict_count", mc_s, 0);
        chk("sat_rst_predict", pt_s, 0);
        rst = 0;
        ex_valid = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
